// File: rtl/run_detector.sv
// run_detector: counts consecutive matching serial samples and flags a hit
// once the run reaches THRESH. The match rule is selected by mode:
// ones, zeros, or repeats of the previous bit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | run is 0, no run in progress
// RUN    | 0 < run < THRESH, run building up
// HIT    | run >= THRESH, z high
// BAD    | code 11, never entered; the next edge forces IDLE and run 0
module run_detector #(
  parameter int CW     = 4,
  parameter int THRESH = 2
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          w,
  input  logic          en,
  input  logic [1:0]    mode,
  output logic          z,
  output logic [1:0]    ht,
  output logic [CW-1:0] run,
  output logic          hit_pulse,
  output logic [7:0]    hit_cnt
);

  if (CW < 2 || CW > 8) begin : g_bad_cw
    $error("run_detector: CW must be in 2..8");
  end
  if (THRESH < 1 || THRESH > (1 << CW) - 1) begin : g_bad_thresh
    $error("run_detector: THRESH must be in 1..2^CW-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HIT  = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam logic [CW-1:0] RUN_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] RUN_ONE = CW'(1);
  localparam logic [CW-1:0] THR     = CW'(THRESH);

  state_t        state_q, state_d;
  logic [CW-1:0] run_q, run_d;
  logic          last_q, last_d;
  logic          last_valid_q, last_valid_d;
  logic [1:0]    mode_q, mode_d;
  logic          hit_pulse_q, hit_pulse_d;
  logic [7:0]    hit_cnt_q, hit_cnt_d;
  logic          match;

  // Per-sample match term for the selected mode; mode 11 behaves like 00.
  always_comb begin
    match = w;
    case (mode)
      2'b01:   match = ~w;
      2'b10:   match = last_valid_q & (w == last_q);
      default: match = w;
    endcase
  end

  // Next-state, run counter and hit bookkeeping; a mode change wins over a sample.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    mode_d       = mode;
    hit_pulse_d  = 1'b0;
    hit_cnt_d    = hit_cnt_q;

    if (mode != mode_q) begin
      run_d        = '0;
      state_d      = S_IDLE;
      last_valid_d = 1'b0;
    end else if (state_q == S_BAD) begin
      run_d   = '0;
      state_d = S_IDLE;
    end else if (en) begin
      if (match) begin
        run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
      end else if (mode == 2'b10) begin
        // In equal-bit mode a mismatching bit starts a new run of length 1.
        run_d = RUN_ONE;
      end else begin
        run_d = '0;
      end

      if (run_d == '0) begin
        state_d = S_IDLE;
      end else if (run_d < THR) begin
        state_d = S_RUN;
      end else begin
        state_d = S_HIT;
      end

      if (mode == 2'b10) begin
        last_d       = w;
        last_valid_d = 1'b1;
      end

      if (state_d == S_HIT && state_q != S_HIT) begin
        hit_pulse_d = 1'b1;
        hit_cnt_d   = hit_cnt_q + 8'd1;
      end
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      run_q        <= '0;
      last_q       <= 1'b0;
      last_valid_q <= 1'b0;
      mode_q       <= 2'b00;
      hit_pulse_q  <= 1'b0;
      hit_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      mode_q       <= mode_d;
      hit_pulse_q  <= hit_pulse_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  assign z         = (state_q == S_HIT);
  assign ht        = state_q;
  assign run       = run_q;
  assign hit_pulse = hit_pulse_q;
  assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_run_detector.sv
// Bench for run_detector: two instances (defaults, and CW=2/THRESH=3) share
// stimulus; each is compared every falling edge against a spec-level model.
module tb_run_detector;

  logic       Clock;
  logic       Resetn;
  logic       w;
  logic       en;
  logic [1:0] mode;

  logic       z1, hp1;
  logic [1:0] ht1;
  logic [3:0] run1;
  logic [7:0] cnt1;
  logic       z2, hp2;
  logic [1:0] ht2;
  logic [1:0] run2;
  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;

  run_detector dut1 (
    .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .mode(mode),
    .z(z1), .ht(ht1), .run(run1), .hit_pulse(hp1), .hit_cnt(cnt1)
  );

  run_detector #(.CW(2), .THRESH(3)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .mode(mode),
    .z(z2), .ht(ht2), .run(run2), .hit_pulse(hp2), .hit_cnt(cnt2)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    int       run;
    bit       last;
    bit       lv;
    bit [1:0] modeq;
    int       cnt;
    bit       pulse;
    int       st;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t s;
    s.run = 0; s.last = 0; s.lv = 0; s.modeq = 0; s.cnt = 0; s.pulse = 0; s.st = 0;
    return s;
  endfunction

  // One rising edge of the specified behaviour, for a given CW and THRESH.
  function automatic mstate_t mstep(mstate_t s, bit wi, bit eni, bit [1:0] mi, int cw, int th);
    mstate_t n = s;
    int maxr = (1 << cw) - 1;
    bit m;
    n.modeq = mi;
    n.pulse = 0;
    if (mi != s.modeq) begin
      n.run = 0; n.st = 0; n.lv = 0;
    end else if (eni) begin
      if (mi == 2'b01)      m = !wi;
      else if (mi == 2'b10) m = s.lv && (wi == s.last);
      else                  m = wi;
      if (m) n.run = (s.run < maxr) ? s.run + 1 : maxr;
      else   n.run = (mi == 2'b10) ? 1 : 0;
      n.st = (n.run == 0) ? 0 : (n.run < th) ? 1 : 2;
      if (mi == 2'b10) begin n.last = wi; n.lv = 1; end
      if (n.st == 2 && s.st != 2) begin
        n.pulse = 1;
        n.cnt = (s.cnt + 1) % 256;
      end
    end
    return n;
  endfunction

  mstate_t m1 = mreset();
  mstate_t m2 = mreset();

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m1 = mreset();
      m2 = mreset();
    end else begin
      m1 = mstep(m1, w, en, mode, 4, 2);
      m2 = mstep(m2, w, en, mode, 2, 3);
    end
  end

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Continuous comparison of both instances against the model.
  always @(negedge Clock) begin
    chk("m1.z",   int'(z1),   (m1.st == 2) ? 1 : 0);
    chk("m1.ht",  int'(ht1),  m1.st);
    chk("m1.run", int'(run1), m1.run);
    chk("m1.hp",  int'(hp1),  int'(m1.pulse));
    chk("m1.cnt", int'(cnt1), m1.cnt);
    chk("m2.z",   int'(z2),   (m2.st == 2) ? 1 : 0);
    chk("m2.ht",  int'(ht2),  m2.st);
    chk("m2.run", int'(run2), m2.run);
    chk("m2.hp",  int'(hp2),  int'(m2.pulse));
    chk("m2.cnt", int'(cnt2), m2.cnt);
  end

  // Drive one sample at the falling edge, return just after the rising edge.
  task automatic sample(input bit wi, input bit eni, input bit [1:0] mi);
    @(negedge Clock);
    w = wi; en = eni; mode = mi;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int ht_exp31[7]  = '{1, 2, 0, 1, 2, 2, 0};
    bit w31[7]       = '{1, 1, 0, 1, 1, 1, 0};
    int run_exp32[6] = '{1, 2, 3, 3, 3, 3};
    bit w33[6]       = '{1, 1, 0, 0, 0, 1};
    int run_exp33[6] = '{1, 2, 1, 2, 3, 1};
    int ht_exp33[6]  = '{1, 2, 1, 2, 2, 1};
    int run_exp34[4] = '{1, 1, 2, 2};
    int hp_exp34[4]  = '{0, 0, 1, 0};
    int pulses;

    Resetn = 1'b1; w = 0; en = 0; mode = 2'b00;
    #1 Resetn = 1'b0;
    #2;
    chk("rst.z", int'(z1), 0);
    chk("rst.ht", int'(ht1), 0);
    chk("rst.run", int'(run1), 0);
    chk("rst.hp", int'(hp1), 0);
    chk("rst.cnt", int'(cnt1), 0);
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;

    // Run of ones with defaults.
    for (int i = 0; i < 7; i++) begin
      sample(w31[i], 1, 2'b00);
      chk("r31.ht", int'(ht1), ht_exp31[i]);
    end
    chk("r31.cnt", int'(cnt1), 2);

    // Run of zeros on the narrow instance: saturation at 3.
    sample(0, 0, 2'b01);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      sample(0, 1, 2'b01);
      chk("r32.run", int'(run2), run_exp32[i]);
      pulses += int'(hp2);
      if (i == 2) chk("r32.z", int'(z2), 1);
    end
    chk("r32.pulses", pulses, 1);

    // Equal-bit mode.
    sample(0, 0, 2'b10);
    for (int i = 0; i < 6; i++) begin
      sample(w33[i], 1, 2'b10);
      chk("r33.run", int'(run1), run_exp33[i]);
      chk("r33.ht", int'(ht1), ht_exp33[i]);
    end
    chk("r33.cnt", int'(cnt1), 5);

    // Enable gating.
    sample(0, 0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      sample(1, (i % 2 == 0), 2'b00);
      chk("r34.run", int'(run1), run_exp34[i]);
      chk("r34.hp", int'(hp1), hp_exp34[i]);
    end

    // Mode change while in HIT.
    sample(0, 1, 2'b01);
    chk("r35.run", int'(run1), 0);
    chk("r35.ht", int'(ht1), 0);
    chk("r35.z", int'(z1), 0);
    chk("r35.cnt", int'(cnt1), 6);
    chk("r35.hp", int'(hp1), 0);
    sample(0, 1, 2'b01);
    chk("r35.resume", int'(run1), 1);

    // Saturation in HIT.
    for (int i = 0; i < 20; i++) sample(0, 1, 2'b01);
    chk("sat.run", int'(run1), 15);
    chk("sat.z", int'(z1), 1);

    // Randomised phase with occasional mode changes and async resets.
    for (int i = 0; i < 3000; i++) begin
      bit [1:0] mi;
      mi = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : mode;
      sample(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), mi);
      if ($urandom_range(0, 299) == 0) begin
        #2 Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
      end
    end

    // Async reset in HIT with hit_cnt = 5, then wrap of hit_cnt.
    @(negedge Clock);
    w = 0; en = 0; mode = 2'b00;
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample(1, 1, 2'b00); sample(1, 1, 2'b00); sample(0, 1, 2'b00);
    end
    sample(1, 1, 2'b00); sample(1, 1, 2'b00);
    chk("r36.cnt5", int'(cnt1), 5);
    chk("r36.z1", int'(z1), 1);
    #2 Resetn = 1'b0;
    #1;
    chk("r36.z", int'(z1), 0);
    chk("r36.run", int'(run1), 0);
    chk("r36.ht", int'(ht1), 0);
    chk("r36.cnt", int'(cnt1), 0);
    @(negedge Clock);
    w = 0; en = 0; mode = 2'b00;
    Resetn = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sample(1, 1, 2'b00); sample(1, 1, 2'b00); sample(0, 1, 2'b00);
      if (i == 254) chk("wrap.255", int'(cnt1), 255);
    end
    chk("wrap.0", int'(cnt1), 0);

    @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
